// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU sequencing FSM with memory handshake, retire counter and traps
module multicycle_controller #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_control,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Timeout fires on the TIMEOUT-th consecutive cycle without mem_ready.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] op_q;
    logic [7:0] wait_cnt;
    logic [2:0] next_state;
    logic       retire;
    logic       waiting;
    logic       timeout;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout = waiting && (wait_cnt == WAIT_LAST);

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_IDLE:   if (run) next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_SLT: next_state = S_WB;
                    OP_LW, OP_SW: next_state = S_MEM;
                    OP_HALT: begin
                        next_state = S_HALT;
                        retire     = 1'b1;
                    end
                    default: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout) begin
                    next_state = S_HALT;
                end
            end
            S_WB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= 4'd0;
            wait_cnt    <= 8'd0;
            instr_count <= '0;
            error       <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) op_q <= opcode;
            if (waiting && (next_state == state)) wait_cnt <= wait_cnt + 8'd1;
            else                                  wait_cnt <= 8'd0;
            if (retire)  instr_count <= instr_count + 1'b1;
            if (timeout) error <= 1'b1;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        alu_control = 4'd0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  alu_control = ALU_ADD;
                    OP_ADDI: begin alu_control = ALU_ADD; alu_src = 1'b1; end
                    OP_SUB:  alu_control = ALU_SUB;
                    OP_AND:  alu_control = ALU_AND;
                    OP_OR:   alu_control = ALU_OR;
                    OP_SLT:  alu_control = ALU_SLT;
                    OP_LW, OP_SW: begin alu_control = ALU_ADD; alu_src = 1'b1; end
                    OP_BEQ: begin
                        alu_control = ALU_SUB;
                        pc_write    = zero;
                        pc_src      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req     = 1'b1;
                i_or_d      = 1'b1;
                mem_write   = (op_q == OP_SW);
                alu_control = ALU_ADD;
                alu_src     = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q != OP_ADDI) && (op_q != OP_LW);
                mem_to_reg = (op_q == OP_LW);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle sequencing FSM for the 16-bit CPU datapath: PC, single shared instruction/data memory, 4-entry reg_file, ALU.
- Splits each instruction into FETCH / DECODE / EXEC / MEM / WB steps.
- Drives all datapath enables and muxes, and handshakes with the shared memory.
- Also counts retired instructions and traps on memory timeout or the HALT opcode.

Parameters:
- TIMEOUT, 15, max cycles to wait for mem_ready in one access before error trap (1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  leave IDLE and start executing.
- opcode  input  4  instruction[15:12] from the instruction register.
- zero  input  1  ALU Zero flag.
- mem_ready  input  1  memory access completes this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  write when mem_req=1; 0 means read.
- i_or_d  output  1  memory address select: 0=PC, 1=ALU result.
- ir_write  output  1  load the instruction register.
- pc_write  output  1  update PC.
- pc_src  output  1  next PC select: 0=PC+2, 1=branch target.
- reg_write  output  1  reg_file write enable.
- reg_dst  output  1  write register select: 1=instruction[7:6] (rd), 0=instruction[9:8] (rt).
- mem_to_reg  output  1  write data select: 1=memory data, 0=ALUOut.
- alu_src  output  1  ALU B input: 1=sign-extended imm8, 0=RD2.
- alu_control  output  4  ALU operation.
- state  output  3  current state, for debug.
- halted  output  1  HALT state reached.
- error  output  1  memory timeout trap.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (synchronous, overrides everything, including mid-access):
  - state=IDLE; op_q=0; wait counter=0; instr_count=0; halted=0; error=0.
  - All control outputs are 0 while in IDLE.
- Control outputs are combinational from state, op_q, zero and mem_ready. Unlisted outputs are 0 in each state.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_req=1, i_or_d=0.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle): op_q<=opcode, go to EXEC. All later states use op_q, never opcode.
- EXEC, by op_q:
  - 0000 ADD: alu_control=0010, alu_src=0, go to WB.
  - 0001 ADDI: alu_control=0010, alu_src=1, go to WB.
  - 0010 SUB: alu_control=0110, alu_src=0, go to WB.
  - 0011 AND: alu_control=0000, alu_src=0, go to WB.
  - 0100 OR: alu_control=0001, alu_src=0, go to WB.
  - 0101 SLT: alu_control=0111, alu_src=0, go to WB.
  - 0110 LW / 0111 SW: alu_control=0010, alu_src=1, go to MEM.
  - 1000 BEQ: alu_control=0110, alu_src=0. pc_write=zero, pc_src=1. Go to FETCH and retire.
  - 1111 HALT: go to HALT and retire.
  - 1001-1110: NOP. No enables asserted, go to FETCH and retire.
- MEM:
  - mem_req=1, i_or_d=1, mem_write=(op_q==0111). alu_control=0010 and alu_src=1 are held.
  - On mem_ready=1: LW goes to WB; SW goes to FETCH and retires.
- WB (1 cycle):
  - reg_write=1. reg_dst=1 for R-type (0000, 0010-0101), 0 for ADDI and LW. mem_to_reg=(op_q==0110).
  - Go to FETCH and retire.
- Retire: instr_count increments by 1 on the transition edge. Wraps modulo 2^CNT_W.
- Wait counter:
  - Counts cycles in FETCH or MEM with mem_ready=0. Cleared whenever mem_ready=1 or state changes.
  - If it reaches TIMEOUT while mem_ready=0: go to HALT, error<=1. The pending access is abandoned with no ir_write, pc_write or retire.
  - mem_ready=1 on the same cycle the count reaches TIMEOUT: the access completes and there is no error.
- HALT:
  - halted=1, all other control outputs 0.
  - Leaves only on reset; run is ignored.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect.
- mem_ready outside FETCH/MEM is ignored.
- reg_write, ir_write and pc_write are never asserted together in the same cycle.

Test Plan:
- ADDI with mem_ready tied high, run pulse:
  - States go IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - In WB: reg_write=1, reg_dst=0, mem_to_reg=0. In EXEC: alu_src=1, alu_control=0010.
  - instr_count goes 0 to 1 after WB.
- LW, with mem_ready asserted 3 cycles late in both FETCH and MEM:
  - FETCH lasts 4 cycles, MEM lasts 4 cycles.
  - In MEM: i_or_d=1, mem_write=0. Then WB with mem_to_reg=1.
  - 11 cycles from first FETCH to return to FETCH.
- SW then BEQ:
  - SW: mem_write=1 in MEM, no WB, returns to FETCH.
  - BEQ with zero=1: pc_write=1 and pc_src=1 in EXEC. With zero=0: pc_write=0.
  - Both retire, instr_count=2.
- mem_ready held low in FETCH, TIMEOUT=15:
  - After 15 wait cycles, state=HALT and error=1.
  - ir_write and pc_write never asserted; instr_count unchanged.
- Opcode 1111 → HALT, halted=1, run toggling ignored. Opcode 1010 → NOP returns to FETCH with no enables and instr_count+1.
- Reset asserted during MEM wait:
  - Next cycle: state=IDLE, all outputs 0, instr_count=0, error=0.
  - Restart with run proceeds normally.
